// File: rtl/mc_ctrl.sv
// Multicycle control sequencer for an RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes, the memory handshake, the mux selects and the one-hot
// immediate-extender select. It counts retired instructions and traps on
// illegal encodings or memory requests that are not acknowledged in time.
module mc_ctrl #(
  parameter int unsigned INSTRET_W   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 br_taken,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           npc_sel,
  output logic                 reg_write,
  output logic [1:0]           wd_sel,
  output logic [5:0]           ext_op,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_mode,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  // Wait counter only has to reach MEM_TIMEOUT before the trap fires.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } iclass_t;

  state_t            state;
  iclass_t           iclass;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_shift;
  logic              shift_ok;
  logic              legal;
  logic              mem_phase;
  logic              timed_out;
  logic [5:0]        ext_sel;

  // Instruction class from the IR opcode; the IR is stable from DECODE to WB.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    iclass = C_NONE;
    case (opcode)
      7'b0110011: iclass = C_R;
      7'b0010011: iclass = C_IALU;
      7'b0000011: iclass = C_LOAD;
      7'b0100011: iclass = C_STORE;
      7'b1100011: iclass = C_BRANCH;
      7'b1101111: iclass = C_JAL;
      7'b1100111: iclass = C_JALR;
      7'b0110111: iclass = C_LUI;
      7'b0010111: iclass = C_AUIPC;
      default:    iclass = C_NONE;
    endcase
  end

  // Immediate shifts carry funct7; only SRAI may use 0100000.
  assign is_shift  = (iclass == C_IALU) && (funct3 == 3'b001 || funct3 == 3'b101);
  assign shift_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000 && funct3 == 3'b101);
  assign legal     = (iclass != C_NONE) && (!is_shift || shift_ok);

  // A request times out when the final allowed cycle passes without ack.
  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign timed_out = (MEM_TIMEOUT != 0) && mem_phase && !mem_ack && (wait_cnt == WAIT_MAX);

  // One-hot extender select, only meaningful while an instruction is in flight.
  always_comb begin
    ext_sel = 6'b000000;
    case (iclass)
      C_IALU:           ext_sel = is_shift ? 6'b100000 : 6'b010000;
      C_LOAD, C_JALR:   ext_sel = 6'b010000;
      C_STORE:          ext_sel = 6'b001000;
      C_BRANCH:         ext_sel = 6'b000100;
      C_LUI, C_AUIPC:   ext_sel = 6'b000010;
      C_JAL:            ext_sel = 6'b000001;
      default:          ext_sel = 6'b000000;
    endcase
    ext_op = 6'b000000;
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB)
      ext_op = ext_sel;
  end

  // Datapath strobes and selects; ack-dependent strobes fire in the ack cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    npc_sel      = 2'b00;
    reg_write    = 1'b0;
    wd_sel       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_mode     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
      end
      S_EXEC: begin
        case (iclass)
          C_R:              alu_mode  = 2'b10;
          C_IALU: begin
            alu_src_b = 1'b1;
            alu_mode  = 2'b10;
          end
          C_LOAD, C_STORE,
          C_LUI:            alu_src_b = 1'b1;
          C_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          C_BRANCH: begin
            alu_mode = 2'b01;
            pc_write = 1'b1;
            npc_sel  = br_taken ? 2'b01 : 2'b00;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (iclass == C_STORE);
        pc_write     = mem_ack && (iclass == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (iclass)
          C_LOAD:  wd_sel = 2'b01;
          C_JAL,
          C_JALR:  wd_sel = 2'b10;
          default: wd_sel = 2'b00;
        endcase
        case (iclass)
          C_JAL:   npc_sel = 2'b10;
          C_JALR:  npc_sel = 2'b11;
          default: npc_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign state_o = state;

  // Sequencer state, wait counter, sticky trap and retired-instruction count.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      // Cleared whenever a request is not pending, so it starts at 0 on entry.
      wait_cnt <= '0;
      if (pc_write)
        instret <= instret + INSTRET_W'(1);
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            state <= S_DECODE;
          end else if (timed_out) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_BRANCH:        state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            state <= (iclass == C_STORE) ? S_FETCH : S_WB;
          end else if (timed_out) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. Each instruction is expanded into its
// expected cycle-by-cycle trace from the sequencing rules (memory delays and
// branch outcome chosen up front); the trace drives the inputs and a single
// negedge process compares every DUT output against it.
module tb_mc_ctrl;

  localparam int IW  = 8;
  localparam int TMO = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OPS [9] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BR,
                                     OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic br_taken = 1'b0;
  logic mem_ack = 1'b0;

  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
  logic alu_src_a, alu_src_b, trap;
  logic [1:0] npc_sel, wd_sel, alu_mode, trap_cause;
  logic [5:0] ext_op;
  logic [2:0] state_o;
  logic [IW-1:0] instret;

  always #5 clk = ~clk;

  mc_ctrl #(.INSTRET_W(IW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .npc_sel(npc_sel), .reg_write(reg_write), .wd_sel(wd_sel), .ext_op(ext_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_mode(alu_mode),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o), .instret(instret)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          req, we, asel, irw, pcw;
    logic [1:0]    npc;
    logic          rw;
    logic [1:0]    wd;
    logic [5:0]    ext;
    logic          a, b;
    logic [1:0]    mode;
    logic          trp;
    logic [1:0]    cause;
    logic [IW-1:0] cnt;
  } exp_t;

  exp_t exp_cur;
  bit   exp_valid = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  // Model state: retired count, trap bookkeeping.
  logic [IW-1:0] m_instret = '0;
  logic [1:0]    m_cause = '0;
  bit            m_trapped = 1'b0;

  // Observation log used by the literal checks.
  logic [31:0] st_log;
  int mem_cyc, fetch_cyc, regw_cnt, we_cnt;
  logic [1:0] wb_wd, ex_npc;
  logic [5:0] dec_ext;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic clear_log();
    st_log = '0; mem_cyc = 0; fetch_cyc = 0; regw_cnt = 0; we_cnt = 0;
    wb_wd = 2'bxx; ex_npc = 2'bxx; dec_ext = 6'bxxxxxx;
  endtask

  // Per-cycle comparison of every output against the expected trace entry.
  always @(negedge clk) begin
    exp_t act;
    if (exp_valid) begin
      act = '{st: state_o, req: mem_req, we: mem_we, asel: mem_addr_sel, irw: ir_write,
              pcw: pc_write, npc: npc_sel, rw: reg_write, wd: wd_sel, ext: ext_op,
              a: alu_src_a, b: alu_src_b, mode: alu_mode, trp: trap, cause: trap_cause,
              cnt: instret};
      n_chk++;
      if (act === exp_cur) n_pass++;
      else $display("FAIL cycle@%0t: got %h, expected %h (state %0d vs %0d)",
                    $time, act, exp_cur, act.st, exp_cur.st);
      st_log = {st_log[27:0], 1'b0, state_o};
      if (state_o == 3'd4 && mem_req && mem_addr_sel) mem_cyc++;
      if (state_o == 3'd1 && mem_req) fetch_cyc++;
      if (reg_write) regw_cnt++;
      if (mem_we) we_cnt++;
      if (state_o == 3'd5) wb_wd = wd_sel;
      if (state_o == 3'd2) dec_ext = ext_op;
      if (state_o == 3'd3 && pc_write) ex_npc = npc_sel;
    end
  end

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op == OP_IALU) begin
      if (f3 == 3'b001) return f7 == 7'h00;
      if (f3 == 3'b101) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    foreach (OPS[i]) if (op == OPS[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] ext_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_IALU:           return (f3 == 3'b001 || f3 == 3'b101) ? 6'b100000 : 6'b010000;
      OP_LOAD, OP_JALR:  return 6'b010000;
      OP_STORE:          return 6'b001000;
      OP_BR:             return 6'b000100;
      OP_LUI, OP_AUIPC:  return 6'b000010;
      OP_JAL:            return 6'b000001;
      default:           return 6'b000000;
    endcase
  endfunction

  function automatic exp_t blank(input int st);
    exp_t e;
    e = '0;
    e.st = 3'(st);
    e.cnt = m_instret;
    if (st == 6) begin
      e.trp = 1'b1;
      e.cause = m_cause;
    end
    return e;
  endfunction

  // One clock cycle: inputs applied just after a rising edge, checked at negedge.
  task automatic cyc(input exp_t e, input logic ack, input logic br, input logic rst);
    mem_ack = ack; br_taken = br; reset = rst;
    exp_cur = e; exp_valid = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0;
  endtask

  task automatic do_reset();
    m_instret = '0; m_cause = '0; m_trapped = 1'b0;
    cyc(blank(0), 1'b0, 1'b0, 1'b1);
    cyc(blank(0), 1'b1, 1'b0, 1'b1);
    cyc(blank(0), rnd_bit(), rnd_bit(), 1'b0);
  endtask

  task automatic enter_trap(input logic [1:0] cause);
    m_cause = cause; m_trapped = 1'b1;
    for (int i = 0; i < 3; i++) cyc(blank(6), rnd_bit(), rnd_bit(), 1'b0);
  endtask

  // Expand one instruction into its expected trace and play it.
  // dfetch/dmem: cycle index of the ack (> TMO means never); abort_mem: MEM
  // cycle index in which reset is pulsed instead (-1 for none).
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic br, input int dfetch, input int dmem, input int abort_mem);
    exp_t e;
    logic ack;
    logic [5:0] x;
    opcode = op; funct3 = f3; funct7 = f7;
    x = ext_of(op, f3);
    for (int i = 0; i <= TMO; i++) begin
      ack = (i == dfetch);
      e = blank(1); e.req = 1'b1; e.irw = ack;
      cyc(e, ack, rnd_bit(), 1'b0);
      if (ack) break;
    end
    if (dfetch > TMO) begin enter_trap(2'b10); return; end
    e = blank(2); e.ext = x;
    cyc(e, rnd_bit(), rnd_bit(), 1'b0);
    if (!legal(op, f3, f7)) begin enter_trap(2'b01); return; end
    e = blank(3); e.ext = x;
    case (op)
      OP_R:               e.mode = 2'b10;
      OP_IALU:            begin e.b = 1'b1; e.mode = 2'b10; end
      OP_LOAD, OP_STORE,
      OP_LUI:             e.b = 1'b1;
      OP_AUIPC:           begin e.a = 1'b1; e.b = 1'b1; end
      OP_BR:              e.mode = 2'b01;
      default: ;
    endcase
    if (op == OP_BR) begin
      e.pcw = 1'b1; e.npc = br ? 2'b01 : 2'b00;
      cyc(e, rnd_bit(), br, 1'b0);
      m_instret++;
      return;
    end
    cyc(e, rnd_bit(), rnd_bit(), 1'b0);
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i <= TMO; i++) begin
        if (i == abort_mem) begin
          m_instret = '0;
          cyc(blank(0), 1'b0, 1'b0, 1'b1);
          cyc(blank(0), 1'b0, 1'b0, 1'b0);
          return;
        end
        ack = (i == dmem);
        e = blank(4); e.ext = x; e.req = 1'b1; e.asel = 1'b1; e.we = (op == OP_STORE);
        e.pcw = ack && (op == OP_STORE);
        cyc(e, ack, rnd_bit(), 1'b0);
        if (ack) break;
      end
      if (dmem > TMO) begin enter_trap(2'b10); return; end
      if (op == OP_STORE) begin m_instret++; return; end
    end
    e = blank(5); e.ext = x; e.rw = 1'b1; e.pcw = 1'b1;
    e.wd  = (op == OP_LOAD) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
    e.npc = (op == OP_JAL) ? 2'b10 : (op == OP_JALR) ? 2'b11 : 2'b00;
    cyc(e, rnd_bit(), rnd_bit(), 1'b0);
    m_instret++;
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 99) < 3) ? TMO + 1 : int'($urandom_range(0, TMO));
  endfunction

  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    @(posedge clk); #1;
    do_reset();

    // R-type, zero-wait memory.
    clear_log();
    do_instr(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, -1);
    check("r_states", st_log, 32'h0000_1235);
    check("r_next_fetch", 32'(state_o), 32'd1);
    check("r_instret", 32'(instret), 32'd1);
    check("r_regwrite_cnt", 32'(regw_cnt), 32'd1);
    check("r_ext", 32'(dec_ext), 32'h0);

    // LOAD with ack three cycles late in MEM.
    clear_log();
    do_instr(OP_LOAD, 3'b010, 7'h00, 1'b0, 0, 3, -1);
    check("ld_states", st_log, 32'h1234_4445);
    check("ld_mem_cycles", 32'(mem_cyc), 32'd4);
    check("ld_wd_sel", 32'(wb_wd), 32'd1);
    check("ld_ext", 32'(dec_ext), 32'b010000);

    // Branch taken, then not taken.
    clear_log();
    do_instr(OP_BR, 3'b000, 7'h00, 1'b1, 0, 0, -1);
    check("br_states", st_log, 32'h0000_0123);
    check("br_taken_npc", 32'(ex_npc), 32'd1);
    check("br_ext", 32'(dec_ext), 32'b000100);
    check("br_regwrite", 32'(regw_cnt), 32'd0);
    clear_log();
    do_instr(OP_BR, 3'b001, 7'h00, 1'b0, 0, 0, -1);
    check("br_not_taken_npc", 32'(ex_npc), 32'd0);
    check("br_regwrite2", 32'(regw_cnt), 32'd0);
    check("br_instret", 32'(instret), 32'd4);

    // SRAI legal, then with a bad funct7.
    clear_log();
    do_instr(OP_IALU, 3'b101, 7'b0100000, 1'b0, 0, 0, -1);
    check("srai_ext", 32'(dec_ext), 32'b100000);
    check("srai_instret", 32'(instret), 32'd5);
    do_instr(OP_IALU, 3'b101, 7'b0000001, 1'b0, 0, 0, -1);
    check("ill_state", 32'(state_o), 32'd6);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    check("ill_instret_held", 32'(instret), 32'd5);

    // Fetch never acknowledged.
    do_reset();
    clear_log();
    do_instr(OP_R, 3'b000, 7'h00, 1'b0, TMO + 1, 0, -1);
    check("tmo_fetch_cycles", 32'(fetch_cyc), 32'd5);
    check("tmo_state", 32'(state_o), 32'd6);
    check("tmo_cause", 32'(trap_cause), 32'd2);
    check("tmo_mem_req", 32'(mem_req), 32'd0);

    // Reset pulse in the middle of a STORE's memory phase.
    do_reset();
    do_instr(OP_R, 3'b000, 7'h00, 1'b0, 1, 0, -1);
    do_instr(OP_LUI, 3'b000, 7'h00, 1'b0, 0, 0, -1);
    clear_log();
    do_instr(OP_STORE, 3'b010, 7'h00, 1'b0, 0, 3, 1);
    check("st_rst_we_cycles", 32'(we_cnt), 32'd1);
    check("st_rst_instret", 32'(instret), 32'd0);
    check("st_rst_state", 32'(state_o), 32'd1);
    clear_log();
    do_instr(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, -1);
    check("st_rst_no_we", 32'(we_cnt), 32'd0);
    clear_log();
    do_instr(OP_STORE, 3'b000, 7'h00, 1'b0, 0, 0, -1);
    check("st_we_cycles", 32'(we_cnt), 32'd1);
    check("st_instret", 32'(instret), 32'd2);

    // Retired counter wraps modulo 2^IW.
    do_reset();
    for (int i = 0; i < 260; i++)
      do_instr((i % 2 == 0) ? OP_R : OP_LUI, 3'b000, 7'h00, 1'b0, 0, 0, -1);
    check("instret_wrap", 32'(instret), 32'd4);

    // Randomized instruction mix with random memory latencies.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        op = 7'h7f;
        for (int t = 0; t < 20; t++) begin
          op = 7'($urandom);
          if (!legal(op, 3'b000, 7'h00)) break;
        end
        if (legal(op, 3'b000, 7'h00)) op = 7'h7f;
      end else begin
        op = OPS[$urandom_range(0, 8)];
      end
      case ($urandom_range(0, 9))
        0:       f7 = 7'($urandom);
        1, 2:    f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      do_instr(op, 3'($urandom), f7, rnd_bit(), rnd_delay(), rnd_delay(), -1);
      if (m_trapped) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control sequencer for the RV32I core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC/IR/register-file write enables, the unified memory request handshake and mux selects.
- Drives the 6-bit one-hot ext_op bus into the immediate extender.
- Sits between the IR fields, the branch comparator and the datapath; also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 255, max extra wait cycles per memory request; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
br_taken  in  1  branch condition from comparator, valid in EXEC
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  request is a store
mem_addr_sel  out  1  0=PC, 1=ALU result
ir_write  out  1  latch instruction register
pc_write  out  1  update PC with npc_sel source
npc_sel  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target
reg_write  out  1  register-file write strobe
wd_sel  out  2  00 ALU, 01 memory data, 10 PC+4
ext_op  out  6  extender select: 100000 I-shamt, 010000 I, 001000 S, 000100 B, 000010 U, 000001 J, 000000 none
alu_src_a  out  1  0=rs1, 1=PC (AUIPC)
alu_src_b  out  1  0=rs2, 1=immediate
alu_mode  out  2  00 add, 01 compare, 10 funct-decoded
trap  out  1  sticky fault flag
trap_cause  out  2  01 illegal instruction, 10 memory timeout
state_o  out  3  current state: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 TRAP
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async): state=IDLE, instret=0, trap=0, trap_cause=0, wait counter=0. All outputs are 0 while in IDLE.
- IDLE -> FETCH unconditionally after the first clock edge following reset release.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ack: ir_write=1 in the same cycle, then -> DECODE.
- DECODE:
  - Classify opcode.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Other opcode, or I-ALU shift (funct3 001/101) with funct7 not 0000000/0100000 (0100000 legal only for funct3 101): -> TRAP, cause 01.
  - Otherwise -> EXEC.
- ext_op:
  - Combinational from opcode/funct3; valid in DECODE, EXEC, MEM, WB; 000000 in IDLE, FETCH, TRAP.
  - I-ALU with funct3 001/101 -> I-shamt.
  - I-ALU other, LOAD, JALR -> I.
  - STORE -> S. BRANCH -> B. LUI, AUIPC -> U. JAL -> J. R -> none.
- EXEC:
  - Operand selects per class: R alu_src_b=0, alu_mode=10; I-ALU imm, 10; LOAD/STORE imm, 00; AUIPC alu_src_a=1, imm, 00; LUI imm, 00; BRANCH rs2, 01.
  - BRANCH: pc_write=1, npc_sel = br_taken ? 01 : 00, retire, -> FETCH.
  - LOAD/STORE -> MEM. All others -> WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On ack, STORE: pc_write=1, npc_sel=00, retire, -> FETCH.
  - On ack, LOAD: -> WB.
- WB:
  - reg_write=1, pc_write=1, then -> FETCH.
  - wd_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - npc_sel: 10 for JAL, 11 for JALR, else 00.
- Retire: instret += 1 (wraps modulo 2^INSTRET_W) in the cycle pc_write=1.
- TRAP: all strobes 0, trap=1, trap_cause held. Absorbing state; only reset exits.
- Memory handshake:
  - Zero-wait ack (same cycle as first mem_req) is allowed.
  - mem_ack outside FETCH/MEM is ignored.
  - mem_req stays high and mem_we/mem_addr_sel stay stable until ack.
- Timeout (MEM_TIMEOUT>0):
  - Wait counter clears on entry to FETCH/MEM and increments per request cycle without ack.
  - Ack accepted in request cycles 0..MEM_TIMEOUT.
  - No ack in cycle MEM_TIMEOUT -> TRAP, cause 10. No strobe is issued that cycle.
- Latency with zero-wait memory: BRANCH 3 cycles; R/I/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.
- Reset asserted mid-instruction: immediate return to IDLE; no pc_write/reg_write issued; instret cleared.

Test Plan:
- Reset release, mem_ack tied 1, R-type (opcode 0110011): state_o 0,1,2,3,5,1; reg_write and pc_write high in WB only; instret=1; ext_op=000000.
- LOAD (0000011), mem_ack delayed 3 cycles in MEM: mem_req high for 4 MEM cycles with mem_addr_sel=1; WB with wd_sel=01; ext_op=010000; total 8 cycles.
- BRANCH with br_taken=1, then with br_taken=0: npc_sel=01 then 00; ext_op=000100; reg_write never asserted; instret +2.
- SRAI (0010011, funct3 101, funct7 0100000) gives ext_op=100000. Same with funct7 0000001 -> TRAP, trap_cause=01, held until reset.
- MEM_TIMEOUT=4, mem_ack held 0 in FETCH: 5 request cycles, then state_o=6, trap_cause=10, mem_req=0.
- Reset pulse asserted during MEM of a STORE: outputs 0 immediately, instret=0, no mem_we after release until the next instruction's MEM.
